// File: rtl/fifo_seq_ctrl_if.sv
// Handshake bundle between the FIFO test sequencer and the FIFO/board side.
interface fifo_seq_ctrl_if #(
    parameter int unsigned DW = 6,
    parameter int unsigned CW = 6
);
    logic          start;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          busy;
    logic          done;
    logic          err;
    logic          timeout;
    logic [7:0]    err_cnt;

    // Sequencer side
    modport master (
        input  start, fifo_full, fifo_empty, fifo_cnt, fifo_dout,
        output fifo_din, fifo_wr_en, fifo_rd_en, busy, done, err, timeout, err_cnt
    );

    // FIFO / board side
    modport slave (
        output start, fifo_full, fifo_empty, fifo_cnt, fifo_dout,
        input  fifo_din, fifo_wr_en, fifo_rd_en, busy, done, err, timeout, err_cnt
    );
endinterface

// File: rtl/fifo_seq_ctrl.sv
// FIFO test sequencer: fills the FIFO with an incrementing pattern, waits for
// the flags to settle, drains it and counts read-back mismatches.
module fifo_seq_ctrl #(
    parameter int unsigned DW        = 6,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned CW        = 6,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned AUTO_LOOP = 0
) (
    input  logic            clk,
    input  logic            rst,
    fifo_seq_ctrl_if.master bus
);
    localparam int unsigned NW  = $clog2(DEPTH + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_SETTLE_W, S_READ, S_FLUSH, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [DW-1:0]   exp_data_q, exp_data_d;
    logic [NW-1:0]   wr_num_q, wr_num_d;
    logic [NW-1:0]   rd_num_q, rd_num_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            rd_vld_q;
    logic            err_q, err_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            busy_q, done_q;

    logic            wr_en_c, rd_en_c, wd_hit_c;
    logic            unused_cnt;

    // The FIFO count is status only; it does not steer the sequencer.
    assign unused_cnt = ^bus.fifo_cnt;

    // Enables decode straight from state so a reset drops them at once.
    assign wr_en_c  = (state_q == S_WRITE) & ~bus.fifo_full & (wr_num_q < NW'(DEPTH));
    assign rd_en_c  = (state_q == S_READ) & ~bus.fifo_empty & (rd_num_q < wr_num_q);
    assign wd_hit_c = (wd_q == WDW'(TIMEOUT - 1));

    assign bus.fifo_wr_en = wr_en_c;
    assign bus.fifo_rd_en = rd_en_c;
    assign bus.fifo_din   = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.timeout    = timeout_q;
    assign bus.err_cnt    = err_cnt_q;

    // Next-state, counters, read-back compare and watchdog.
    always_comb begin
        state_d    = state_q;
        wr_data_d  = wr_data_q;
        exp_data_d = exp_data_q;
        wr_num_d   = wr_num_q;
        rd_num_d   = rd_num_q;
        wd_d       = '0;
        settle_d   = settle_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        err_cnt_d  = err_cnt_q;

        // Read data lands one cycle after the enable; compare it wherever we are.
        if (rd_vld_q) begin
            exp_data_d = exp_data_q + DW'(1);
            if (bus.fifo_dout != exp_data_q) begin
                err_d     = 1'b1;
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_WRITE;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    err_cnt_d = 8'd0;
                    wr_num_d  = '0;
                    rd_num_d  = '0;
                end
            end
            S_WRITE: begin
                if (wr_en_c) begin
                    wr_data_d = wr_data_q + DW'(1);
                    wr_num_d  = wr_num_q + NW'(1);
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
                if ((wr_num_q == NW'(DEPTH)) || bus.fifo_full) begin
                    state_d  = S_SETTLE_W;
                    settle_d = '0;
                end else if (!wr_en_c && wd_hit_c) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                end
            end
            S_SETTLE_W: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = S_READ;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_READ: begin
                if (rd_en_c) begin
                    rd_num_d = rd_num_q + NW'(1);
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
                if (rd_num_q == wr_num_q) begin
                    state_d = S_FLUSH;
                end else if (!rd_en_c && wd_hit_c) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (AUTO_LOOP != 0) begin
                    state_d   = S_WRITE;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    err_cnt_d = 8'd0;
                    wr_num_d  = '0;
                    rd_num_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_data_q  <= '0;
            exp_data_q <= '0;
            wr_num_q   <= '0;
            rd_num_q   <= '0;
            wd_q       <= '0;
            settle_q   <= '0;
            rd_vld_q   <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_data_q  <= wr_data_d;
            exp_data_q <= exp_data_d;
            wr_num_q   <= wr_num_d;
            rd_num_q   <= rd_num_d;
            wd_q       <= wd_d;
            settle_q   <= settle_d;
            rd_vld_q   <= rd_en_c;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            err_cnt_q  <= err_cnt_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end
endmodule
